boot_byte_streamer: RTL

Bridges the control module's 32-bit boot-data word handshake to the byte-wide game loader input. Accepts words over a four-phase req/ack handshake and unpacks them into a byte FIFO. It drops every byte that precedes the first iNES sync byte and truncates the stream at `rom_size` bytes. Bytes are presented downstream with a valid/ready handshake. Sits between the CtrlModule boot-data outputs and GameLoader, replacing the ad-hoc FIFO/skip logic in the top level.

---
 rtl/boot_byte_streamer_if.sv | 27 ++
 rtl/boot_byte_streamer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/boot_byte_streamer_if.sv
// Handshake bundle for boot_byte_streamer.
//   host_bootdata / host_bootdata_req / host_bootdata_ack : four-phase word
//     intake from the control module (req raised with data, ack answers,
//     req falls, ack falls).
//   byte_out / byte_valid / byte_ready : byte stream to the game loader.
//     A byte moves on every rising clock edge where byte_valid and
//     byte_ready are both high; byte_out holds while valid waits on ready.
// slave  : the streamer side (drives ack and the byte stream).
// master : the control module / loader side.
interface boot_byte_streamer_if;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport slave (
    input  host_bootdata, host_bootdata_req, byte_ready,
    output host_bootdata_ack, byte_out, byte_valid
  );

  modport master (
    output host_bootdata, host_bootdata_req, byte_ready,
    input  host_bootdata_ack, byte_out, byte_valid
  );
endinterface

// File: rtl/boot_byte_streamer.sv
// boot_byte_streamer: takes 32-bit boot words over a four-phase req/ack
// handshake, unpacks them into a first-word-fall-through byte FIFO, drops
// every byte ahead of the first SYNC_BYTE, truncates the stream at rom_size
// bytes and presents the result on a valid/ready byte stream.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   restart          : synchronous clear, same effect as reset while high
//   rom_size         : number of stream bytes to accept
//   bus (slave)      : word intake handshake and byte output stream
//   sync_found       : SYNC_BYTE has reached the FIFO head (sticky)
//   bytes_loaded     : bytes pushed into the stream, saturates at rom_size
//   done             : all rom_size bytes accepted and drained (sticky)
//   dbg_state_o      : intake FSM state, 0 = IDLE, 1 = ACK
module boot_byte_streamer #(
  parameter int         DEPTH_LOG2 = 5,
  parameter logic [7:0] SYNC_BYTE  = 8'h4E,
  parameter bit         MSB_FIRST  = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        restart,
  input  logic [31:0]                 rom_size,
  boot_byte_streamer_if.slave         bus,
  output logic                        sync_found,
  output logic [31:0]                 bytes_loaded,
  output logic                        done,
  output logic                        dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  // A word is only latched when four free slots exist, so the unpacker can
  // never overrun the FIFO whatever the downstream does.
  localparam logic [CW-1:0] SPACE_LIMIT = CW'(DEPTH - 4);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           word_q, word_d;
  logic [2:0]            ucnt_q, ucnt_d;     // bytes left in the unpacker
  logic [31:0]           loaded_q, loaded_d;
  logic                  sync_q, sync_d;
  logic                  done_q, done_d;

  logic        fifo_empty;
  logic [7:0]  head;
  logic        head_is_sync;
  logic        out_valid;
  logic        drop;
  logic        pop;
  logic        push;
  logic [7:0]  push_byte;
  logic [31:0] remaining;
  logic        latch;
  logic [2:0]  take;

  assign fifo_empty   = (count_q == '0);
  assign head         = mem_q[rd_ptr_q];
  assign head_is_sync = !fifo_empty && (head == SYNC_BYTE);
  assign out_valid    = !fifo_empty && (sync_q || head == SYNC_BYTE);
  // Before sync, garbage at the head is discarded at one byte per cycle.
  assign drop         = !fifo_empty && !sync_q && (head != SYNC_BYTE);
  assign pop          = (out_valid && bus.byte_ready) || drop;
  assign push         = (ucnt_q != 3'd0);
  assign push_byte    = MSB_FIRST ? word_q[31:24] : word_q[7:0];
  assign remaining    = rom_size - loaded_q;
  // When nothing remains the word is still acknowledged, but loads zero bytes.
  assign take         = (remaining >= 32'd4) ? 3'd4 : remaining[2:0];
  assign latch        = (state_q == ST_IDLE) && bus.host_bootdata_req &&
                        (ucnt_q == 3'd0) && (count_q <= SPACE_LIMIT) && !restart;

  // Intake FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Intake FSM: next state. ACK only exits on req low, so no word can be
  // latched in the cycle the ack falls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (latch) state_d = ST_ACK;
      ST_ACK:  if (!bus.host_bootdata_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (restart) state_d = ST_IDLE;
  end

  // Intake FSM: outputs.
  always_comb begin
    bus.host_bootdata_ack = (state_q == ST_ACK);
    dbg_state_o           = (state_q == ST_ACK);
  end

  // Datapath next state: unpacker, FIFO pointers, counters, sticky flags.
  always_comb begin
    word_d   = word_q;
    ucnt_d   = ucnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    sync_d   = sync_q | head_is_sync;
    done_d   = done_q;

    if (push) begin
      word_d   = MSB_FIRST ? {word_q[23:0], 8'h00} : {8'h00, word_q[31:8]};
      ucnt_d   = ucnt_q - 3'd1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      loaded_d = loaded_q + 32'd1;
    end
    // latch requires an empty unpacker, so it never collides with push.
    if (latch) begin
      word_d = bus.host_bootdata;
      ucnt_d = take;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Evaluated on next-state values so done appears the cycle after the
    // final pop (or one cycle after release when rom_size is 0).
    if ((loaded_d == rom_size) && (ucnt_d == 3'd0) && (count_d == '0)) begin
      done_d = 1'b1;
    end

    if (restart) begin
      word_d   = '0;
      ucnt_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      loaded_d = '0;
      sync_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q   <= '0;
      ucnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      loaded_q <= '0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      word_q   <= word_d;
      ucnt_q   <= ucnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      sync_q   <= sync_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push && !restart) begin
      mem_q[wr_ptr_q] <= push_byte;
    end
  end

  // Outputs are gated by a non-empty FIFO so reset shows zeros at once.
  assign bus.byte_valid = out_valid;
  assign bus.byte_out   = fifo_empty ? 8'h00 : head;
  assign sync_found     = sync_q | head_is_sync;
  assign bytes_loaded   = loaded_q;
  assign done           = done_q;

endmodule
